adder_input_packer: RTL and testbench
=====================================

// Module: adder_input_packer
// PURPOSE
//   Serial-to-parallel packer feeding the 16-input FP32 adder tree. Collects a
//   stream of FP32 words (one per Valid_In) into N lanes and presents the whole
//   group in one cycle with a Valid_Out pulse. The tree has no backpressure, so
//   the packer never stalls. Early group close zero-pads unused lanes (+0.0).
// PARAMETERS
//   DATA_W    32  lane width in bits (FP32)
//   N_INPUTS  16  lanes per group (>=2); IDX_W = $clog2(N_INPUTS)
// PORTS
//   Clk        in   1              clock, all logic on rising edge
//   Rst        in   1              synchronous reset, active-high
//   Data_In    in   DATA_W         serial FP32 word
//   Valid_In   in   1              Data_In valid this cycle
//   Last_In    in   1              closes current group; qualified by Valid_In
//   Data_Out   out  N_INPUTS*DATA_W  packed group; lane k = [k*DATA_W +: DATA_W]
//   Valid_Out  out  1              one-cycle pulse, Data_Out holds a new group
//   Lane_Cnt   out  IDX_W+1        real (unpadded) words in current Data_Out
// BEHAVIOUR
//   Reset: Data_Out=0, Valid_Out=0, Lane_Cnt=0, fill index=0, state=EMPTY,
//     fill buffer cleared to 0.
//   Lane order: first word of a group -> lane 0 (Data_Out[DATA_W-1:0], adder
//     Data1); word i -> lane i.
//   Two registers: fill buffer (internal) and output register (Data_Out).
//   States: EMPTY (idx=0, buffer all zero), FILL (1<=idx<=N_INPUTS-1).
//     EMPTY --Valid_In & !Last_In--> FILL (word -> lane 0, idx=1).
//     FILL  --Valid_In, idx<N-1, !Last_In--> FILL (word -> lane idx, idx+1).
//     Any state, Valid_In & (Last_In | idx==N-1) -> group closes: buffer with
//       this word in lane idx copied to Data_Out, Lane_Cnt=idx+1, Valid_Out=1
//       next cycle, buffer zeroed, idx=0, state EMPTY, all same edge.
//   Latency: Valid_Out asserts exactly 1 cycle after the closing word's edge.
//   Valid_Out deasserts next cycle unless another group closes (N_INPUTS=1
//     excluded, so back-to-back pulses are >=2 cycles apart except Last_In
//     on consecutive single-word groups, which pulse every cycle).
//   Data_Out and Lane_Cnt hold between pulses; only updated on a close.
//   Valid_In=0: no state change; Data_In/Last_In ignored.
//   Last_In on the N-th word: identical to a normal full close.
//   Last_In on first word (EMPTY): single-word group, lanes 1..N-1 = 0.
//   Zero padding: unfilled lanes are 32'h0000_0000 (+0.0), sum-neutral.
//   Rst mid-group: partial group discarded, no Valid_Out, Data_Out cleared.
//   Rst dominates a simultaneous closing word (word dropped).
// CONFIGURATION
//   ADDER_PACKER_GROUP_CNT_EN defined: extra port Group_Cnt out 16 -- count of
//     Valid_Out pulses since reset, increments same edge Valid_Out rises,
//     wraps 16'hFFFF->0, reset 0. Not defined: port and counter absent;
//     all other behaviour identical.
// TESTING
//   16 x 32'h3F80_0000 consecutive -> one Valid_Out pulse 1 cycle after 16th
//     word, all lanes 3F80_0000, Lane_Cnt=16.
//   Words 1..16 = 32'h4000_0000+i with random Valid_In gaps -> lane i-1 holds
//     word i, single pulse, Data_Out stable until next close.
//   3 words + Last_In on 3rd -> lanes 0-2 data, lanes 3-15 = 0, Lane_Cnt=3.
//   32 words continuous -> two pulses exactly 16 cycles apart, no word lost.
//   7 words then Rst 1 cycle, then 16 words -> no pulse for partial, clean
//     group after; macro on: Group_Cnt=1.
//   Macro on, 65536 single-word Last_In groups -> Group_Cnt wraps to 0.

Source files
------------

// File: rtl/adder_input_packer.sv
// Serial-to-parallel packer: gathers FP32 words into N_INPUTS lanes for the adder tree, zero-padding early closes.
// Optional Group_Cnt output under `ADDER_PACKER_GROUP_CNT_EN`; never stalls, output updates 1 cycle after closing word.
module adder_input_packer #(
  parameter int DATA_W   = 32,
  parameter int N_INPUTS = 16,
  localparam int IDX_W   = $clog2(N_INPUTS)
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [DATA_W-1:0]          Data_In,
  input  logic                       Valid_In,
  input  logic                       Last_In,
  output logic [N_INPUTS*DATA_W-1:0] Data_Out,
  output logic                       Valid_Out,
  output logic [IDX_W:0]             Lane_Cnt
`ifdef ADDER_PACKER_GROUP_CNT_EN
  ,
  output logic [15:0]                Group_Cnt
`endif
);

  typedef enum logic {EMPTY, FILL} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d, lane;
  logic [N_INPUTS*DATA_W-1:0] buf_q, buf_d, group;
  logic                       close;

  // The closing word never lands in the buffer; it is merged straight into the outgoing group.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    group   = buf_q;
    lane    = (state_q == EMPTY) ? '0 : idx_q;
    close   = Valid_In && (Last_In || (lane == LAST_IDX));
    group[int'(lane)*DATA_W +: DATA_W] = Data_In;
    if (Valid_In) begin
      if (close) begin
        state_d = EMPTY;
        idx_d   = '0;
        buf_d   = '0;
      end else begin
        state_d = FILL;
        idx_d   = lane + IDX_W'(1);
        buf_d   = group;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Data_Out  <= '0;
      Valid_Out <= 1'b0;
      Lane_Cnt  <= '0;
    end else begin
      Valid_Out <= close;
      if (close) begin
        Data_Out <= group;
        Lane_Cnt <= (IDX_W+1)'(lane) + (IDX_W+1)'(1);
      end
    end
  end

`ifdef ADDER_PACKER_GROUP_CNT_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Group_Cnt <= '0;
    end else if (close) begin
      Group_Cnt <= Group_Cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_input_packer.sv
// Directed bench for adder_input_packer: inputs change on the falling edge, outputs sampled one falling edge later.
module tb_adder_input_packer;
  localparam int DW = 32;
  localparam int N  = 16;
  localparam int W  = DW * N;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [DW-1:0] Data_In;
  logic          Valid_In;
  logic          Last_In;
  logic [W-1:0]  Data_Out;
  logic          Valid_Out;
  logic [4:0]    Lane_Cnt;
`ifdef ADDER_PACKER_GROUP_CNT_EN
  logic [15:0]   Group_Cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  adder_input_packer #(.DATA_W(DW), .N_INPUTS(N)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Data_In   (Data_In),
    .Valid_In  (Valid_In),
    .Last_In   (Last_In),
    .Data_Out  (Data_Out),
    .Valid_Out (Valid_Out),
    .Lane_Cnt  (Lane_Cnt)
`ifdef ADDER_PACKER_GROUP_CNT_EN
    ,
    .Group_Cnt (Group_Cnt)
`endif
  );

  // One clock of stimulus; on return the outputs reflect the edge that consumed it.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic l);
    Valid_In = v;
    Data_In  = d;
    Last_In  = l;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    n_cmp++; if (Valid_Out !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", Valid_Out); end
    n_cmp++; if (Data_Out !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", Data_Out); end
    n_cmp++; if (Lane_Cnt !== 5'd0) begin n_err++; $display("FAIL reset_lane_cnt got %0d want 0", Lane_Cnt); end
`ifdef ADDER_PACKER_GROUP_CNT_EN
    n_cmp++; if (Group_Cnt !== 16'd0) begin n_err++; $display("FAIL reset_group_cnt got %0d want 0", Group_Cnt); end
`endif
    Rst = 1'b0;
  endtask

  task automatic test_full_group();
    int early = 0;
    logic [W-1:0] exp = {N{32'h3F80_0000}};
    for (int i = 0; i < N - 1; i++) begin
      step(1'b1, 32'h3F80_0000, 1'b0);
      if (Valid_Out) early++;
    end
    n_cmp++; if (early !== 0) begin n_err++; $display("FAIL full_early_pulse got %0d want 0", early); end
    step(1'b1, 32'h3F80_0000, 1'b0);
    n_cmp++; if (Valid_Out !== 1'b1) begin n_err++; $display("FAIL full_valid got %b want 1", Valid_Out); end
    n_cmp++; if (Data_Out !== exp) begin n_err++; $display("FAIL full_data got %h want %h", Data_Out, exp); end
    n_cmp++; if (Lane_Cnt !== 5'd16) begin n_err++; $display("FAIL full_lane_cnt got %0d want 16", Lane_Cnt); end
    step(1'b0, '0, 1'b0);
    n_cmp++; if (Valid_Out !== 1'b0) begin n_err++; $display("FAIL full_pulse_end got %b want 0", Valid_Out); end
    n_cmp++; if (Data_Out !== exp) begin n_err++; $display("FAIL full_hold got %h want %h", Data_Out, exp); end
  endtask

  task automatic test_gaps();
    int pulses = 0;
    logic [W-1:0] exp = '0;
    for (int i = 1; i <= N; i++) begin
      // Idle cycles carry junk data and Last_In, which must be ignored.
      repeat ($urandom_range(0, 2)) begin
        step(1'b0, 32'hDEAD_BEEF, 1'b1);
        if (Valid_Out) pulses++;
      end
      exp[(i-1)*DW +: DW] = 32'h4000_0000 + DW'(i);
      step(1'b1, 32'h4000_0000 + DW'(i), 1'b0);
      if (i < N && Valid_Out) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL gaps_early_pulse got %0d want 0", pulses); end
    n_cmp++; if (Valid_Out !== 1'b1) begin n_err++; $display("FAIL gaps_valid got %b want 1", Valid_Out); end
    n_cmp++; if (Data_Out !== exp) begin n_err++; $display("FAIL gaps_data got %h want %h", Data_Out, exp); end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 32'hFFFF_FFFF, 1'b0);
      if (Valid_Out) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL gaps_extra_pulse got %0d want 0", pulses); end
    n_cmp++; if (Data_Out !== exp) begin n_err++; $display("FAIL gaps_hold got %h want %h", Data_Out, exp); end
  endtask

  task automatic test_early_close();
    logic [W-1:0] exp = '0;
    exp[0*DW +: DW] = 32'h1111_1111;
    exp[1*DW +: DW] = 32'h2222_2222;
    exp[2*DW +: DW] = 32'h3333_3333;
    step(1'b1, 32'h1111_1111, 1'b0);
    step(1'b0, 32'h9999_9999, 1'b1);
    n_cmp++; if (Valid_Out !== 1'b0) begin n_err++; $display("FAIL early_idle_last got %b want 0", Valid_Out); end
    step(1'b1, 32'h2222_2222, 1'b0);
    step(1'b1, 32'h3333_3333, 1'b1);
    n_cmp++; if (Valid_Out !== 1'b1) begin n_err++; $display("FAIL early_valid got %b want 1", Valid_Out); end
    n_cmp++; if (Data_Out !== exp) begin n_err++; $display("FAIL early_data got %h want %h", Data_Out, exp); end
    n_cmp++; if (Lane_Cnt !== 5'd3) begin n_err++; $display("FAIL early_lane_cnt got %0d want 3", Lane_Cnt); end
    step(1'b0, '0, 1'b0);
  endtask

  task automatic test_single_word();
    logic [W-1:0] exp;
    for (int k = 0; k < 3; k++) begin
      exp = '0;
      exp[DW-1:0] = 32'hA000_0000 + DW'(k);
      step(1'b1, 32'hA000_0000 + DW'(k), 1'b1);
      n_cmp++; if (Valid_Out !== 1'b1) begin n_err++; $display("FAIL single_valid[%0d] got %b want 1", k, Valid_Out); end
      n_cmp++; if (Data_Out !== exp) begin n_err++; $display("FAIL single_data[%0d] got %h want %h", k, Data_Out, exp); end
      n_cmp++; if (Lane_Cnt !== 5'd1) begin n_err++; $display("FAIL single_lane_cnt[%0d] got %0d want 1", k, Lane_Cnt); end
    end
    step(1'b0, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int pulse_at[$];
    logic [W-1:0] exp;
    for (int i = 0; i < 2 * N; i++) begin
      step(1'b1, 32'hC000_0000 + DW'(i), 1'b0);
      if (Valid_Out) begin
        pulse_at.push_back(i);
        for (int k = 0; k < N; k++)
          exp[k*DW +: DW] = 32'hC000_0000 + DW'((i / N) * N + k);
        n_cmp++; if (Data_Out !== exp) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", i, Data_Out, exp); end
      end
    end
    n_cmp++; if (pulse_at.size() !== 2) begin n_err++; $display("FAIL b2b_pulse_count got %0d want 2", pulse_at.size()); end
    if (pulse_at.size() == 2) begin
      n_cmp++; if (pulse_at[1] - pulse_at[0] !== N) begin n_err++; $display("FAIL b2b_spacing got %0d want %0d", pulse_at[1] - pulse_at[0], N); end
    end
    step(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset_mid_group();
    int pulses = 0;
    logic [W-1:0] exp;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 32'h7700_0000 + DW'(i), 1'b0);
      if (Valid_Out) pulses++;
    end
    // A closing word coincident with reset must be dropped.
    Rst = 1'b1;
    step(1'b1, 32'h5555_5555, 1'b1);
    Rst = 1'b0;
    n_cmp++; if (Valid_Out !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got %b want 0", Valid_Out); end
    n_cmp++; if (Data_Out !== '0) begin n_err++; $display("FAIL rst_mid_data got %h want 0", Data_Out); end
    n_cmp++; if (Lane_Cnt !== 5'd0) begin n_err++; $display("FAIL rst_mid_lane_cnt got %0d want 0", Lane_Cnt); end
    for (int i = 0; i < N; i++) begin
      exp[i*DW +: DW] = 32'h0000_0100 + DW'(i);
      step(1'b1, 32'h0000_0100 + DW'(i), 1'b0);
      if (i < N - 1 && Valid_Out) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL rst_mid_stray_pulse got %0d want 0", pulses); end
    n_cmp++; if (Valid_Out !== 1'b1) begin n_err++; $display("FAIL rst_mid_after_valid got %b want 1", Valid_Out); end
    n_cmp++; if (Data_Out !== exp) begin n_err++; $display("FAIL rst_mid_after_data got %h want %h", Data_Out, exp); end
`ifdef ADDER_PACKER_GROUP_CNT_EN
    n_cmp++; if (Group_Cnt !== 16'd1) begin n_err++; $display("FAIL rst_mid_group_cnt got %0d want 1", Group_Cnt); end
`endif
    step(1'b0, '0, 1'b0);
  endtask

`ifdef ADDER_PACKER_GROUP_CNT_EN
  task automatic test_group_cnt_wrap();
    Rst = 1'b1;
    step(1'b0, '0, 1'b0);
    Rst = 1'b0;
    for (int j = 0; j < 65536; j++) begin
      step(1'b1, DW'(j), 1'b1);
      if (j == 65534) begin
        n_cmp++; if (Group_Cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_max got %h want ffff", Group_Cnt); end
      end
    end
    n_cmp++; if (Group_Cnt !== 16'd0) begin n_err++; $display("FAIL wrap_zero got %h want 0", Group_Cnt); end
    step(1'b0, '0, 1'b0);
  endtask
`endif

  initial begin
    Rst      = 1'b1;
    Valid_In = 1'b0;
    Last_In  = 1'b0;
    Data_In  = '0;
    @(negedge Clk);
    test_reset();
    test_full_group();
    test_gaps();
    test_early_close();
    test_single_word();
    test_back_to_back();
    test_reset_mid_group();
`ifdef ADDER_PACKER_GROUP_CNT_EN
    test_group_cnt_wrap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
